// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor: FSM state encoding,
// retry-counter width and a helper used to size the shared cycle counter.
package pll_sup_pkg;

  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAILED    = 3'd4
  } sup_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level crossing into the clk_i domain.
// Both flops clear to 0 on the asynchronous active-high reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: non-blocking assignments, so the second flop takes the first flop's pre-edge value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, releases the system reset and
// retries on lock timeout until a sticky FAULT is raised.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               CLKIN,
  input  logic               RESET,
  input  logic               LOCK,
  output logic               PLL_RESET,
  output logic               RESET_OUT,
  output logic               READY,
  output logic               FAULT,
  output logic [RETRY_W-1:0] RETRY_COUNT
);

  localparam int CNT_W = $clog2(max3(RESET_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                     LOCK_TIMEOUT_CYCLES)) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t PULSE_LOAD   = cnt_t'(RESET_PULSE_CYCLES);
  localparam cnt_t STABLE_LOAD  = cnt_t'(LOCK_STABLE_CYCLES);
  localparam cnt_t TIMEOUT_LOAD = cnt_t'(LOCK_TIMEOUT_CYCLES);
  localparam cnt_t CNT_ONE      = cnt_t'(1);

  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

  sup_state_e         state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_reset_q, pll_reset_d;
  logic               reset_out_q, reset_out_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               lock_s;
  logic               cnt_last;

  sync2 u_lock_sync (
    .clk_i (CLKIN),
    .rst_i (RESET),
    .d_i   (LOCK),
    .q_o   (lock_s)
  );

  assign cnt_last = (cnt_q == CNT_ONE);

  // NOTE: every signal gets its default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_last) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Lock is tested before expiry, so a lock arriving on the last cycle wins.
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = STABLE_LOAD;
        end else if (cnt_last) begin
          if (retry_q < RETRY_MAX) begin
            state_d = ST_PLL_RST;
            cnt_d   = PULSE_LOAD;
            retry_d = retry_q + RETRY_ONE;
          end else begin
            state_d = ST_FAILED;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = TIMEOUT_LOAD;
        end else if (cnt_last) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      // Lock loss is not a timeout: restart the PLL without touching the retry budget.
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          cnt_d   = PULSE_LOAD;
        end
      end

      ST_FAILED: begin
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = PULSE_LOAD;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state and can never glitch.
  always_comb begin
    pll_reset_d = (state_d == ST_PLL_RST) || (state_d == ST_FAILED);
    reset_out_d = (state_d != ST_RUN);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAILED);
  end

  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= PULSE_LOAD;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      reset_out_q <= reset_out_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign PLL_RESET   = pll_reset_q;
  assign RESET_OUT   = reset_out_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, hand-written corner
// sequences and a randomized run against an elapsed-time reference model.
module tb_pll_lock_supervisor;

  localparam int RP   = 4;
  localparam int ST   = 8;
  localparam int TO   = 32;
  localparam int MAXR = 2;

  logic       CLKIN = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCK  = 1'b0;
  logic       PLL_RESET, RESET_OUT, READY, FAULT;
  logic [3:0] RETRY_COUNT;
  logic [7:0] dut_vec;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  pll_lock_supervisor #(
    .RESET_PULSE_CYCLES  (RP),
    .LOCK_STABLE_CYCLES  (ST),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MAXR)
  ) dut (
    .CLKIN       (CLKIN),
    .RESET       (RESET),
    .LOCK        (LOCK),
    .PLL_RESET   (PLL_RESET),
    .RESET_OUT   (RESET_OUT),
    .READY       (READY),
    .FAULT       (FAULT),
    .RETRY_COUNT (RETRY_COUNT)
  );

  always #5 CLKIN = ~CLKIN;

  assign dut_vec = {PLL_RESET, RESET_OUT, READY, FAULT, RETRY_COUNT};

  function automatic logic [7:0] ev(input logic pll, input logic ro, input logic rdy,
                                    input logic flt, input int rc);
    return {pll, ro, rdy, flt, 4'(rc)};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got pll=%b rst_out=%b ready=%b fault=%b retry=%0d, want pll=%b rst_out=%b ready=%b fault=%b retry=%0d",
                  name, cyc, act[7], act[6], act[5], act[4], act[3:0],
                  exp[7], exp[6], exp[5], exp[4], exp[3:0]);
  endtask

  // Starts at a falling edge; LOCK takes effect from the next rising edge.
  task automatic run_to(input logic lock_v, input int target);
    LOCK = lock_v;
    while (cyc < target) begin
      @(posedge CLKIN);
      @(negedge CLKIN);
      cyc++;
    end
  endtask

  // Releases RESET on a falling edge; the half cycle that follows is cycle 0.
  task automatic apply_reset(input logic lock_v);
    LOCK  = lock_v;
    RESET = 1'b1;
    repeat (2) @(negedge CLKIN);
    RESET = 1'b0;
    cyc   = 0;
  endtask

  // Reference model: phase plus cycles spent in it, lock seen two edges late.
  localparam int PH_PRST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAIL = 4;
  int m_phase   = PH_PRST;
  int m_elapsed = 0;
  int m_retry   = 0;
  bit m_hist[$];

  task automatic model_reset();
    m_phase   = PH_PRST;
    m_elapsed = 0;
    m_retry   = 0;
    m_hist    = '{1'b0, 1'b0};
  endtask

  task automatic model_step(input logic lock_raw);
    bit ls;
    int n, nxt;
    ls = m_hist[1];
    m_hist.push_front(lock_raw);
    void'(m_hist.pop_back());
    n   = m_elapsed + 1;
    nxt = m_phase;
    case (m_phase)
      PH_PRST: if (n >= RP) nxt = PH_WAIT;
      PH_WAIT: begin
        if (ls) nxt = PH_STAB;
        else if (n >= TO) begin
          if (m_retry < MAXR) begin
            m_retry++;
            nxt = PH_PRST;
          end else nxt = PH_FAIL;
        end
      end
      PH_STAB: if (!ls) nxt = PH_WAIT; else if (n >= ST) nxt = PH_RUN;
      PH_RUN:  if (!ls) nxt = PH_PRST;
      default: ;
    endcase
    m_elapsed = (nxt != m_phase) ? 0 : n;
    m_phase   = nxt;
  endtask

  function automatic logic [7:0] model_vec();
    return {(m_phase == PH_PRST) || (m_phase == PH_FAIL), m_phase != PH_RUN,
            m_phase == PH_RUN, m_phase == PH_FAIL, 4'(m_retry)};
  endfunction

  typedef struct {
    logic       lock;
    int         ncyc;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic lock_v;
    int   hold;

    // Nominal lock, then lock loss in RUN and re-lock (cycle numbers from reset release).
    vecs[0]  = '{1'b0, 0,  ev(1,1,0,0,0), "reset_state"};
    vecs[1]  = '{1'b0, 3,  ev(1,1,0,0,0), "pll_rst_c3"};
    vecs[2]  = '{1'b0, 1,  ev(0,1,0,0,0), "wait_c4"};
    vecs[3]  = '{1'b0, 6,  ev(0,1,0,0,0), "wait_c10"};
    vecs[4]  = '{1'b1, 10, ev(0,1,0,0,0), "stable_c20"};
    vecs[5]  = '{1'b1, 1,  ev(0,0,1,0,0), "run_c21"};
    vecs[6]  = '{1'b1, 4,  ev(0,0,1,0,0), "run_c25"};
    vecs[7]  = '{1'b0, 2,  ev(0,0,1,0,0), "loss_sync_lat_c27"};
    vecs[8]  = '{1'b0, 1,  ev(1,1,0,0,0), "loss_reset_c28"};
    vecs[9]  = '{1'b0, 3,  ev(1,1,0,0,0), "loss_pulse_c31"};
    vecs[10] = '{1'b0, 1,  ev(0,1,0,0,0), "loss_wait_c32"};
    vecs[11] = '{1'b1, 10, ev(0,1,0,0,0), "relock_stable_c42"};
    vecs[12] = '{1'b1, 1,  ev(0,0,1,0,0), "relock_run_c43"};

    apply_reset(1'b0);
    foreach (vecs[i]) begin
      run_to(vecs[i].lock, cyc + vecs[i].ncyc);
      check(vecs[i].name, dut_vec, vecs[i].exp);
    end

    // One-cycle lock glitch four cycles into STABLE restarts the stable window.
    apply_reset(1'b0);
    run_to(1'b1, 7);
    run_to(1'b0, 8);
    run_to(1'b1, 13);
    check("glitch_no_early_run", dut_vec, ev(0,1,0,0,0));
    run_to(1'b1, 18);
    check("glitch_stable_c18", dut_vec, ev(0,1,0,0,0));
    run_to(1'b1, 19);
    check("glitch_run_c19", dut_vec, ev(0,0,1,0,0));

    // Lock rising exactly in the timeout-expiry cycle must win.
    apply_reset(1'b0);
    run_to(1'b0, 33);
    run_to(1'b1, 36);
    check("simul_no_retry", dut_vec, ev(0,1,0,0,0));
    run_to(1'b1, 43);
    check("simul_stable_c43", dut_vec, ev(0,1,0,0,0));
    run_to(1'b1, 44);
    check("simul_run", dut_vec, ev(0,0,1,0,0));

    // Asynchronous reset in the middle of STABLE with one retry consumed.
    apply_reset(1'b0);
    run_to(1'b0, 36);
    check("retry1_pulse", dut_vec, ev(1,1,0,0,1));
    run_to(1'b0, 40);
    run_to(1'b1, 45);
    check("stable_before_rst", dut_vec, ev(0,1,0,0,1));
    RESET = 1'b1;
    #1;
    check("rst_stable_async", dut_vec, ev(1,1,0,0,0));
    apply_reset(1'b0);
    run_to(1'b0, 3);
    check("restart_pulse_c3", dut_vec, ev(1,1,0,0,0));
    run_to(1'b0, 4);
    check("restart_wait_c4", dut_vec, ev(0,1,0,0,0));

    // Three timeouts: retries 1 and 2, then FAILED, sticky despite LOCK.
    apply_reset(1'b0);
    run_to(1'b0, 35);
    check("to1_last_wait", dut_vec, ev(0,1,0,0,0));
    run_to(1'b0, 36);
    check("to1_retry", dut_vec, ev(1,1,0,0,1));
    run_to(1'b0, 39);
    check("to1_pulse_end", dut_vec, ev(1,1,0,0,1));
    run_to(1'b0, 40);
    check("to1_wait", dut_vec, ev(0,1,0,0,1));
    run_to(1'b0, 72);
    check("to2_retry", dut_vec, ev(1,1,0,0,2));
    run_to(1'b0, 107);
    check("to3_last_wait", dut_vec, ev(0,1,0,0,2));
    run_to(1'b0, 108);
    check("failed", dut_vec, ev(1,1,0,1,2));
    for (int k = 1; k <= 10; k++) begin
      run_to(1'b1, 108 + 10 * k);
      check("fault_sticky", dut_vec, ev(1,1,0,1,2));
    end
    RESET = 1'b1;
    #1;
    check("rst_failed_async", dut_vec, ev(1,1,0,0,0));
    apply_reset(1'b0);
    run_to(1'b0, 3);
    check("after_fail_pulse", dut_vec, ev(1,1,0,0,0));
    run_to(1'b0, 4);
    check("after_fail_wait", dut_vec, ev(0,1,0,0,0));

    // Randomized LOCK with occasional resets against the reference model.
    apply_reset(1'b0);
    model_reset();
    hold   = 0;
    lock_v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        lock_v = 1'($urandom_range(0, 1));
        hold   = $urandom_range(1, 45);
      end
      hold--;
      RESET = ($urandom_range(0, 299) == 0);
      if (RESET) model_reset();
      LOCK = lock_v;
      @(posedge CLKIN);
      if (RESET) model_reset();
      else model_step(LOCK);
      @(negedge CLKIN);
      check("random", dut_vec, model_vec());
    end
    RESET = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
